gf16_kara_mul_seq: RTL and testbench

- Sequenced GF(2^16) multiplier built from one shared combinational 8x8 carry-less multiplier.
- Applies the three Karatsuba partial products over three cycles: LL, then HH, then MM.
- Reduces the 31-bit result modulo a fixed field polynomial and returns it over a valid/ready handshake.
- Sits between the crypto datapath register file and downstream consumers, replacing a full 16x16 array with a time-shared 8-bit core.

---
 rtl/gf_mul_pkg.sv | 37 +++
 rtl/gf16_kara_mul_seq_clmul8.sv | 20 ++
 rtl/gf16_kara_mul_seq.sv | 157 +++++++++++++++
 tb/tb_gf16_kara_mul_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_mul_pkg.sv
// Shared types and constants for the time-shared GF(2^16) Karatsuba multiplier.
package gf_mul_pkg;

  localparam int W  = 16;  // field element width
  localparam int H  = 8;   // half width, operand width of the shared core
  localparam int PW = 31;  // width of the unreduced 16x16 carry-less product

  // Low 16 bits of x^16 + x^12 + x^3 + x + 1; the x^16 term is implicit.
  localparam logic [W-1:0] GF16_POLY_DEFAULT = 16'h100B;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_LL = 3'd1,
    MUL_HH = 3'd2,
    MUL_MM = 3'd3,
    REDUCE = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Fold bits 30..16 of a carry-less product back into the low 16 bits.
  // Top-down order matters: each fold only lands on bits below the one cleared.
  function automatic logic [W-1:0] gf_reduce(input logic [PW-1:0] p,
                                             input logic [W-1:0]  poly);
    logic [PW-1:0] w;
    w = p;
    for (int k = PW - 1; k >= W; k--) begin
      if (w[k]) begin
        w    = w ^ ({15'd0, poly} << (k - W));
        w[k] = 1'b0;
      end else begin
        w = w;
      end
    end
    return w[W-1:0];
  endfunction

endpackage

// File: rtl/gf16_kara_mul_seq_clmul8.sv
// Combinational 8x8 carry-less multiplier: p[k] = XOR of a[i]&b[j] over i+j=k.
module clmul8
  import gf_mul_pkg::*;
(
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  output logic [2*H-2:0] p
);

  // Accumulate every partial-product bit into its output column with XOR.
  always_comb begin
    p = '0;
    for (int i = 0; i < H; i++) begin
      for (int j = 0; j < H; j++) begin
        p[i+j] = p[i+j] ^ (a[i] & b[j]);
      end
    end
  end

endmodule

// File: rtl/gf16_kara_mul_seq.sv
// Sequenced GF(2^16) multiplier: one shared 8x8 carry-less core applied to the
// LL, HH and MM Karatsuba terms over three cycles, then a one-cycle reduction.
module gf16_kara_mul_seq
  import gf_mul_pkg::*;
#(
  parameter logic [W-1:0] POLY    = GF16_POLY_DEFAULT,
  parameter bit           RAW_OUT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_y,
  output logic [PW-1:0] out_raw,
  output logic          busy
);

  state_t          state_r;
  state_t          state_s;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [2*H-2:0]  ll_r;
  logic [2*H-2:0]  hh_r;
  logic [PW-1:0]   p_r;
  logic [W-1:0]    y_r;
  logic [PW-1:0]   raw_r;
  logic [H-1:0]    core_a_s;
  logic [H-1:0]    core_b_s;
  logic [2*H-2:0]  core_p_s;
  logic [PW-1:0]   p_next_s;

  clmul8 u_core (
    .a (core_a_s),
    .b (core_b_s),
    .p (core_p_s)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: fixed walk through the three products and the reduction.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = MUL_LL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL_LL: state_s = MUL_HH;
      MUL_HH: state_s = MUL_MM;
      MUL_MM: state_s = REDUCE;
      REDUCE: state_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Steer the shared core onto the operand halves needed by the current state.
  always_comb begin
    core_a_s = '0;
    core_b_s = '0;
    case (state_r)
      MUL_LL: begin
        core_a_s = a_r[H-1:0];
        core_b_s = b_r[H-1:0];
      end
      MUL_HH: begin
        core_a_s = a_r[W-1:H];
        core_b_s = b_r[W-1:H];
      end
      MUL_MM: begin
        core_a_s = a_r[H-1:0] ^ a_r[W-1:H];
        core_b_s = b_r[H-1:0] ^ b_r[W-1:H];
      end
      default: begin
        core_a_s = '0;
        core_b_s = '0;
      end
    endcase
  end

  // Karatsuba recombination; the middle term is MM with LL and HH cancelled out.
  always_comb begin
    p_next_s = {hh_r, 16'd0}
             ^ {8'd0, (core_p_s ^ ll_r ^ hh_r), 8'd0}
             ^ {16'd0, ll_r};
  end

  // Datapath registers: capture operands, partial products, product and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      ll_r  <= '0;
      hh_r  <= '0;
      p_r   <= '0;
      y_r   <= '0;
      raw_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r <= in_a;
            b_r <= in_b;
          end else begin
            a_r <= a_r;
            b_r <= b_r;
          end
        end
        MUL_LL: ll_r <= core_p_s;
        MUL_HH: hh_r <= core_p_s;
        MUL_MM: p_r  <= p_next_s;
        REDUCE: begin
          y_r   <= gf_reduce(p_r, POLY);
          raw_r <= p_r;
        end
        default: begin
          y_r   <= y_r;
          raw_r <= raw_r;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = (state_r == DONE);
  assign out_y     = y_r;

  generate
    if (RAW_OUT) begin : g_raw
      assign out_raw = raw_r;
    end else begin : g_no_raw
      assign out_raw = '0;
    end
  endgenerate

endmodule

// File: tb/tb_gf16_kara_mul_seq.sv
// Self-checking bench for gf16_kara_mul_seq against a shift-and-add field model.
module tb_gf16_kara_mul_seq;

  localparam logic [15:0] POLY_REF = 16'h100B;
  localparam int          NRAND    = 1000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic [30:0] out_raw;
  logic        busy;

  int checks;
  int failures;

  gf16_kara_mul_seq #(.POLY(POLY_REF), .RAW_OUT(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_raw   (out_raw),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Unreduced carry-less product: XOR of shifted copies of a for each set bit of b.
  function automatic logic [30:0] ref_clmul(input logic [15:0] a, input logic [15:0] b);
    logic [30:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (b[i]) r = r ^ ({15'd0, a} << i);
    return r;
  endfunction

  // Field product by shift-and-add, reducing a*x^i on every step.
  function automatic logic [15:0] ref_gfmul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r, aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[15] ? ((aa << 1) ^ POLY_REF) : (aa << 1);
    end
    return r;
  endfunction

  // Present an operand pair; called and returning #1 after a rising edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      to = 1'b1;
    end else begin
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = 16'($urandom);
      in_b = 16'($urandom);
    end
  endtask

  // Count edges from the accept edge until out_valid rises.
  task automatic wait_valid(output int lat, output bit to);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !out_valid;
  endtask

  // Full transaction with out_ready high; returns the observed result.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] y, output logic [30:0] raw,
                        output int lat, output bit to);
    bit t1, t2;
    out_ready = 1'b1;
    send(a, b, t1);
    lat = 0;
    t2  = 1'b1;
    if (!t1) wait_valid(lat, t2);
    to  = t1 | t2;
    y   = out_y;
    raw = out_raw;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_y !== 16'h0000) begin failures++; $display("FAIL reset_out_y got %h want 0000", out_y); end
    checks++; if (out_raw !== 31'h0) begin failures++; $display("FAIL reset_out_raw got %h want 0", out_raw); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    bit to;
    int lat;
    out_ready = 1'b1;
    send(16'h0001, 16'h0001, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_accept got timeout=%b want 0", to); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_busy got in_ready=%b busy=%b want 0/1", in_ready, busy); end
    wait_valid(lat, to);
    checks++; if (to !== 1'b0 || lat !== 4) begin failures++; $display("FAIL basic_latency got %0d (timeout=%b) want 4", lat, to); end
    checks++; if (out_y !== 16'h0001) begin failures++; $display("FAIL basic_out_y got %h want 0001", out_y); end
    checks++; if (out_raw !== 31'h00000001) begin failures++; $display("FAIL basic_out_raw got %h want 00000001", out_raw); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_after_hs got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reduce;
    logic [15:0] y; logic [30:0] raw; int lat; bit to;
    run_op(16'h8000, 16'h0002, y, raw, lat, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL reduce_timeout got %b want 0", to); end
    checks++; if (raw !== 31'h00010000) begin failures++; $display("FAIL reduce_out_raw got %h want 00010000", raw); end
    checks++; if (y !== 16'h100B) begin failures++; $display("FAIL reduce_out_y got %h want 100b", y); end
  endtask

  task automatic test_ll_zero;
    logic [15:0] y; logic [30:0] raw; int lat; bit to;
    run_op(16'h00FF, 16'h00FF, y, raw, lat, to);
    checks++; if (to !== 1'b0 || raw !== 31'h00005555) begin failures++; $display("FAIL ll_out_raw got %h (timeout=%b) want 00005555", raw, to); end
    checks++; if (y !== 16'h5555) begin failures++; $display("FAIL ll_out_y got %h want 5555", y); end
    run_op(16'hABCD, 16'h0000, y, raw, lat, to);
    checks++; if (to !== 1'b0 || y !== 16'h0000) begin failures++; $display("FAIL zero_out_y got %h (timeout=%b) want 0000", y, to); end
    checks++; if (raw !== 31'h0) begin failures++; $display("FAIL zero_out_raw got %h want 0", raw); end
  endtask

  task automatic test_backpressure;
    bit to; int lat; bit extra;
    out_ready = 1'b0;
    send(16'h8000, 16'h0002, to);
    wait_valid(lat, to);
    checks++; if (to !== 1'b0 || lat !== 4) begin failures++; $display("FAIL bp_latency got %0d (timeout=%b) want 4", lat, to); end
    in_a = 16'h0003; in_b = 16'h0003; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_y !== 16'h100B || out_raw !== 31'h00010000 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle %0d got valid=%b y=%h raw=%h in_ready=%b want 1/100b/00010000/0", i, out_valid, out_y, out_raw, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_late_accept got busy=%b want 1", busy); end
    wait_valid(lat, to);
    checks++; if (to !== 1'b0 || lat !== 4 || out_y !== 16'h0005) begin failures++; $display("FAIL bp_second got y=%h lat=%0d want 0005 lat 4", out_y, lat); end
    @(posedge clk); #1;
    extra = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0) begin failures++; $display("FAIL bp_no_duplicate got extra result=%b want 0", extra); end
  endtask

  task automatic test_reset_midop;
    logic [15:0] y; logic [30:0] raw; int lat; bit to;
    out_ready = 1'b1;
    send(16'h1234, 16'h5678, to);
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midop_reset got valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0003, 16'h0003, y, raw, lat, to);
    checks++; if (to !== 1'b0 || lat !== 4 || y !== 16'h0005 || raw !== 31'h5) begin failures++; $display("FAIL midop_after got y=%h raw=%h lat=%0d want 0005/5/4", y, raw, lat); end
  endtask

  task automatic test_random;
    logic [46:0] exp_q[$];
    logic [46:0] e;
    int sent, got;
    logic [15:0] a, b;
    sent = 0; got = 0;
    fork
      begin
        for (int c = 0; c < 40000 && sent < NRAND; c++) begin
          @(posedge clk); #1;
          a = 16'($urandom); b = 16'($urandom);
          in_a = a; in_b = b;
          if (in_ready && ($urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1;
            exp_q.push_back({ref_clmul(a, b), ref_gfmul(a, b)});
            sent++;
          end else begin
            in_valid = in_ready ? 1'b0 : 1'($urandom_range(0, 1));
          end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40000 && got < NRAND; c++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL rand_unexpected got y=%h want no result", out_y);
            end else begin
              e = exp_q.pop_front();
              checks++; if (out_y !== e[15:0]) begin failures++; $display("FAIL rand_out_y #%0d got %h want %h", got, out_y, e[15:0]); end
              checks++; if (out_raw !== e[46:16]) begin failures++; $display("FAIL rand_out_raw #%0d got %h want %h", got, out_raw, e[46:16]); end
            end
            got++;
          end
        end
      end
    join
    out_ready = 1'b1;
    checks++; if (got !== NRAND || exp_q.size() !== 0) begin failures++; $display("FAIL rand_count got %0d results (%0d pending) want %0d", got, exp_q.size(), NRAND); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_basic;
    test_reduce;
    test_ll_zero;
    test_backpressure;
    test_reset_midop;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
